// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: game state codes,
// winner codes and the default winning score.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEFAULT_WIN_SCORE = 9;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector producing a single-cycle pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, serve/pause delay counter on the 1 ms
// tick, score keeping, serve direction and ball/paddle gating.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = DEFAULT_WIN_SCORE,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int POINT_PAUSE_MS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       start_btn,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [2:0] game_state,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam int MAX_DELAY = (SERVE_DELAY_MS > POINT_PAUSE_MS) ? SERVE_DELAY_MS : POINT_PAUSE_MS;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY_MS);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_PAUSE_MS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN_CNT    = 4'(WIN_SCORE);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             entry, entry_next;
  logic             play_en_next, ball_reset_next, serve_dir_next;
  logic [3:0]       p1_next, p2_next;
  logic [1:0]       winner_next;
  logic             start_pulse;

  btn_sync_edge u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .pulse (start_pulse)
  );

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    p1_next        = p1_score;
    p2_next        = p2_score;
    serve_dir_next = serve_dir;
    winner_next    = winner;

    case (state)
      ST_IDLE: begin
        p1_next     = '0;
        p2_next     = '0;
        winner_next = WIN_NONE;
        if (start_pulse) state_next = ST_SERVE;
      end
      ST_SERVE, ST_POINT: begin
        // The counter is loaded on the first cycle of the state; a tick
        // arriving on that same cycle is deliberately not counted.
        if (entry) begin
          cnt_next = (state == ST_SERVE) ? SERVE_LOAD : POINT_LOAD;
        end else if (clk_1ms && cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_next = (state == ST_SERVE) ? ST_PLAY : ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (p1_miss && p2_miss) begin
          state_next = ST_POINT;
        end else if (p1_miss) begin
          serve_dir_next = 1'b0;
          if (p2_score < WIN_CNT) p2_next = p2_score + 4'd1;
          if (p2_next == WIN_CNT) begin
            state_next  = ST_OVER;
            winner_next = WIN_P2;
          end else begin
            state_next = ST_POINT;
          end
        end else if (p2_miss) begin
          serve_dir_next = 1'b1;
          if (p1_score < WIN_CNT) p1_next = p1_score + 4'd1;
          if (p1_next == WIN_CNT) begin
            state_next  = ST_OVER;
            winner_next = WIN_P1;
          end else begin
            state_next = ST_POINT;
          end
        end
      end
      ST_OVER: begin
        if (start_pulse) begin
          p1_next        = '0;
          p2_next        = '0;
          winner_next    = WIN_NONE;
          serve_dir_next = 1'b1;
          state_next     = ST_SERVE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    entry_next      = (state_next != state);
    play_en_next    = (state_next == ST_PLAY);
    ball_reset_next = (state_next == ST_SERVE) && (state != ST_SERVE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      entry      <= 1'b0;
      play_en    <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      p1_score   <= '0;
      p2_score   <= '0;
      winner     <= WIN_NONE;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      entry      <= entry_next;
      play_en    <= play_en_next;
      ball_reset <= ball_reset_next;
      serve_dir  <= serve_dir_next;
      p1_score   <= p1_next;
      p2_score   <= p2_next;
      winner     <= winner_next;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=3, SERVE_DELAY_MS=4,
// POINT_PAUSE_MS=2 and a 1 ms tick every 10 clocks.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1ms;
  logic       start_btn;
  logic       p1_miss;
  logic       p2_miss;
  logic [2:0] game_state;
  logic       play_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  bit tick_on = 1'b0;

  pong_match_ctrl #(
    .WIN_SCORE      (3),
    .SERVE_DELAY_MS (4),
    .POINT_PAUSE_MS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_1ms    (clk_1ms),
    .start_btn  (start_btn),
    .p1_miss    (p1_miss),
    .p2_miss    (p2_miss),
    .game_state (game_state),
    .play_en    (play_en),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: pass the next rising edge, land on the falling edge, and
  // schedule the tick for the following rising edge.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    if (tick_on) begin
      phase++;
      if (phase == 10) begin
        phase   = 0;
        clk_1ms = 1'b1;
      end else begin
        clk_1ms = 1'b0;
      end
    end else begin
      clk_1ms = 1'b0;
    end
  endtask

  // Called on the entry cycle of SERVE/POINT. A tick is placed on the entry
  // cycle (must be ignored), then n ticks 10 clocks apart follow.
  task automatic timed_phase(input int n, input logic [2:0] st_now, input logic [2:0] st_after,
                             input bit inject, input string tag);
    clk_1ms = 1'b1;
    phase   = 0;
    tick_on = 1'b1;
    adv();
    chk({tag, "_ball_reset_low"}, ball_reset, 0);
    for (int i = 0; i < n * 10 - 1; i++) begin
      if (inject && i == 3) p1_miss = 1'b1;
      if (inject && i == 4) begin p1_miss = 1'b0; p2_miss = 1'b1; end
      if (inject && i == 5) p2_miss = 1'b0;
      adv();
    end
    chk({tag, "_hold_state"}, game_state, st_now);
    chk({tag, "_hold_play_en"}, play_en, 0);
    adv();
    tick_on = 1'b0;
    clk_1ms = 1'b0;
    chk({tag, "_next_state"}, game_state, st_after);
  endtask

  initial begin
    reset     = 1'b0;
    clk_1ms   = 1'b0;
    start_btn = 1'b0;
    p1_miss   = 1'b0;
    p2_miss   = 1'b0;
    adv();
    adv();
    chk("rst_state", game_state, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_ball_reset", ball_reset, 0);
    chk("rst_serve_dir", serve_dir, 1);
    chk("rst_scores", {p1_score, p2_score}, 0);
    chk("rst_winner", winner, 0);
    reset = 1'b1;
    adv();
    adv();
    chk("idle_after_release", game_state, 0);

    // Start button: SERVE with ball_reset on the third edge
    start_btn = 1'b1;
    adv();
    adv();
    chk("start_lat2_state", game_state, 0);
    adv();
    chk("start_lat3_state", game_state, 1);
    chk("start_ball_reset", ball_reset, 1);
    timed_phase(4, 3'd1, 3'd2, 1'b0, "serve1");
    chk("serve1_play_en", play_en, 1);
    start_btn = 1'b0;

    // P2 misses: P1 scores, serve toward P2
    p2_miss = 1'b1;
    adv();
    p2_miss = 1'b0;
    chk("p2miss_p1_score", p1_score, 1);
    chk("p2miss_serve_dir", serve_dir, 1);
    chk("p2miss_state", game_state, 3);
    chk("p2miss_play_en", play_en, 0);
    timed_phase(2, 3'd3, 3'd1, 1'b0, "point1");
    chk("point1_ball_reset", ball_reset, 1);
    timed_phase(4, 3'd1, 3'd2, 1'b0, "serve2");

    // Simultaneous misses
    p1_miss = 1'b1;
    p2_miss = 1'b1;
    adv();
    p1_miss = 1'b0;
    p2_miss = 1'b0;
    chk("both_scores", {p1_score, p2_score}, 8'h10);
    chk("both_serve_dir", serve_dir, 1);
    chk("both_state", game_state, 3);
    timed_phase(2, 3'd3, 3'd1, 1'b0, "point2");
    timed_phase(4, 3'd1, 3'd2, 1'b0, "serve3");

    // Start button during PLAY is ignored
    start_btn = 1'b1;
    repeat (4) adv();
    chk("start_in_play_state", game_state, 2);
    start_btn = 1'b0;
    repeat (3) adv();
    chk("start_in_play_state2", game_state, 2);
    chk("start_in_play_scores", {p1_score, p2_score}, 8'h10);

    // Three P1 misses: P2 reaches WIN_SCORE; stray misses in SERVE/POINT ignored
    for (int i = 1; i <= 3; i++) begin
      p1_miss = 1'b1;
      adv();
      p1_miss = 1'b0;
      chk("rally_p2_score", p2_score, i);
      chk("rally_serve_dir", serve_dir, 0);
      if (i < 3) begin
        chk("rally_state", game_state, 3);
        timed_phase(2, 3'd3, 3'd1, (i == 1), "rally_point");
        timed_phase(4, 3'd1, 3'd2, (i == 1), "rally_serve");
        chk("rally_scores_held", {p1_score, p2_score}, {4'd1, 4'(i)});
      end else begin
        chk("over_state", game_state, 4);
        chk("over_winner", winner, 2);
        chk("over_play_en", play_en, 0);
      end
    end

    p1_miss = 1'b1;
    adv();
    p1_miss = 1'b0;
    p2_miss = 1'b1;
    adv();
    p2_miss = 1'b0;
    chk("over_miss_scores", {p1_score, p2_score}, 8'h13);
    chk("over_miss_state", game_state, 4);

    // Restart from OVER
    start_btn = 1'b1;
    adv();
    adv();
    chk("restart_lat2_state", game_state, 4);
    adv();
    start_btn = 1'b0;
    chk("restart_state", game_state, 1);
    chk("restart_ball_reset", ball_reset, 1);
    chk("restart_scores", {p1_score, p2_score}, 0);
    chk("restart_winner", winner, 0);
    chk("restart_serve_dir", serve_dir, 1);
    timed_phase(4, 3'd1, 3'd2, 1'b0, "serve4");
    p1_miss = 1'b1;
    adv();
    p1_miss = 1'b0;
    chk("pre_reset_p2_score", p2_score, 1);
    timed_phase(2, 3'd3, 3'd1, 1'b0, "point3");

    // Asynchronous reset with the SERVE count at 2
    clk_1ms = 1'b1;
    phase   = 0;
    tick_on = 1'b1;
    adv();
    repeat (20) adv();
    chk("pre_reset_state", game_state, 1);
    chk("pre_reset_serve_dir", serve_dir, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", game_state, 0);
    chk("async_rst_play_en", play_en, 0);
    chk("async_rst_ball_reset", ball_reset, 0);
    chk("async_rst_serve_dir", serve_dir, 1);
    chk("async_rst_scores", {p1_score, p2_score}, 0);
    chk("async_rst_winner", winner, 0);
    tick_on = 1'b0;
    clk_1ms = 1'b0;
    adv();
    adv();
    reset = 1'b1;
    repeat (3) adv();
    chk("post_reset_state", game_state, 0);
    chk("post_reset_play_en", play_en, 0);

    // Resume a full serve after reset
    start_btn = 1'b1;
    repeat (3) adv();
    start_btn = 1'b0;
    chk("resume_state", game_state, 1);
    timed_phase(4, 3'd1, 3'd2, 1'b0, "serve5");
    chk("resume_play_en", play_en, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the VGA Pong game. It owns the game-level state machine (idle, serve countdown, rally, point pause, game over), keeps both players' scores, and decides serve direction. It drives the enables and reset pulses that gate the ball and paddle objects. It sits between the ball object's miss reports and the display and seven-segment logic, and runs on the system clock with the 1 ms tick as a clock enable.

## Interface
Parameters:
- `WIN_SCORE`, default 9: points needed to win; legal range 1..15.
- `SERVE_DELAY_MS`, default 1000: ticks spent in SERVE before play starts; must be ≥1.
- `POINT_PAUSE_MS`, default 500: ticks spent in POINT after a miss; must be ≥1.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `reset`  in  1: asynchronous, active-low reset.
- `clk_1ms`  in  1: one-`clk`-wide tick enable, one pulse per ms.
- `start_btn`  in  1: raw asynchronous start button, active-high.
- `p1_miss`  in  1: one-cycle pulse; ball passed the left (P1) edge.
- `p2_miss`  in  1: one-cycle pulse; ball passed the right (P2) edge.
- `game_state`  out  3: current state encoding.
- `play_en`  out  1: ball and paddles may move.
- `ball_reset`  out  1: one-cycle pulse; recentre the ball.
- `serve_dir`  out  1: 1 = serve toward P2 (right), 0 = toward P1.
- `p1_score`  out  4: P1 points.
- `p2_score`  out  4: P2 points.
- `winner`  out  2: 00 none, 01 P1, 10 P2.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. All other codes return to IDLE.
- `start_btn` passes through a 2-flop synchronizer and a rising-edge detector. The resulting `start_pulse` is one cycle long.
- **IDLE:** scores are held at 0, `play_en`=0. On `start_pulse`, go to SERVE.
- **SERVE:** on entry, load the down-counter with `SERVE_DELAY_MS`. Each `clk_1ms` decrements it. A tick seen with count==1 moves the FSM to PLAY on the next edge, so exactly `SERVE_DELAY_MS` ticks elapse.
- **PLAY:** `play_en`=1.
  - `p1_miss` alone: `p2_score`+1, `serve_dir`←0.
  - `p2_miss` alone: `p1_score`+1, `serve_dir`←1.
  - If the incremented score equals `WIN_SCORE`, go to OVER and set `winner`; otherwise go to POINT.
  - Both misses in the same cycle: no score change, `serve_dir` unchanged, go to POINT.
- **POINT:** `play_en`=0. Load the counter with `POINT_PAUSE_MS` and count ticks the same way as SERVE, then go to SERVE.
- **OVER:** `play_en`=0. Scores and `winner` hold. On `start_pulse`, clear scores and `winner`, set `serve_dir`←1, go to SERVE.
- `ball_reset` is asserted for exactly the first cycle of every SERVE entry.
- Miss pulses outside PLAY are ignored. `start_pulse` outside IDLE and OVER is ignored.
- Scores saturate at `WIN_SCORE` and never wrap.
- The counter width is sized by the larger of the two delays.

## Timing
- All outputs are registered.
- Reset values: `game_state`=IDLE, `play_en`=0, `ball_reset`=0, `serve_dir`=1, `p1_score`=0, `p2_score`=0, `winner`=0, counter=0, synchronizer flops=0.
- Button latency: `start_btn` rising, then `game_state`=SERVE and `ball_reset`=1 three `clk` edges later (2 sync + 1 FSM).
- Miss latency: miss pulse at edge N, then score, `serve_dir`, and `game_state` all update at edge N+1. `play_en` drops at that same edge.
- SERVE→PLAY: `play_en` rises on the edge after the final tick.
- A tick landing on the SERVE/POINT entry cycle is not counted; the counter is loaded on that cycle.
- Reset asserted mid-rally or mid-count returns every output to its reset value immediately (asynchronous). Operation resumes in IDLE after reset is released.

## Structure
- Shared package `pong_pkg`:
  - state encoding constants (IDLE..OVER, width 3);
  - `winner` codes;
  - default `WIN_SCORE`.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge detector, asynchronous active-low reset. It is reusable for the paddle buttons.
- Top of block: FSM, delay counter, and score registers in one module.

## Test plan
Bench setup: `WIN_SCORE`=3, `SERVE_DELAY_MS`=4, `POINT_PAUSE_MS`=2, with `clk_1ms` pulsed every 10 `clk`.

1. Reset release, then press `start_btn` → `ball_reset`=1 for 1 cycle with state SERVE 3 edges later. `play_en`=1 after exactly 4 ticks.
2. `p2_miss` in PLAY → `p1_score`=1 and `serve_dir`=1 at the next edge; state POINT for 2 ticks, then SERVE with a `ball_reset` pulse.
3. `p1_miss` and `p2_miss` in the same cycle → scores unchanged, `serve_dir` unchanged, state POINT.
4. Three `p1_miss` rallies → `p2_score`=3, `winner`=10, state OVER. A further `p1_miss` is ignored. `start_btn` then clears scores and enters SERVE.
5. Miss pulses during SERVE/POINT and `start_btn` during PLAY → no state or score change.
6. Assert `reset` while the SERVE count is at 2 → all outputs take reset values asynchronously; after release, state is IDLE.
